// File: rtl/bus_matrix_pkg.sv
// Shared AXI response codes, error-slave FSM state types and the helper that
// maps a routing fault to its AXI response.
package bus_matrix_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // A security violation is reported as SLVERR, anything else unroutable as DECERR.
  function automatic logic [1:0] err_resp(input logic sec_err);
    return sec_err ? AXI_RESP_SLVERR : AXI_RESP_DECERR;
  endfunction

endpackage

// File: rtl/bus_matrix_sat_cnt.sv
// Saturating up-counter that advances by 0, 1 or 2 per cycle and sticks at
// all-ones. WIDTH must be at least 2 so that an increment of 2 fits.
module bus_matrix_sat_cnt
  import bus_matrix_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH:0]   sum;

  // Add with one guard bit; a carry into the guard bit means saturate.
  always_comb begin
    sum   = {1'b0, cnt_q} + {{(WIDTH-1){1'b0}}, inc_i};
    cnt_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bus_matrix_error_slave.sv
// Default slave of the bus matrix: swallows every unroutable AXI4 transaction
// and answers with DECERR (unmapped) or SLVERR (security violation), keeping
// saturating counts of both error kinds.
//
// Write FSM
//   state  | meaning
//   W_IDLE | awready high, waiting for an errored write address
//   W_DATA | wready high, draining data beats until wlast
//   W_RESP | bvalid high with captured id/resp until bready
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for an errored read address
//   R_DATA | rvalid high, returning zero beats until the rlast handshake
module bus_matrix_error_slave
  import bus_matrix_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ID_WIDTH-1:0]   s_awid,
  input  logic [7:0]            s_awlen,
  input  logic                  s_awvalid,
  input  logic                  s_aw_sec_err_i,
  output logic                  s_awready,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [ID_WIDTH-1:0]   s_bid,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [7:0]            s_arlen,
  input  logic                  s_arvalid,
  input  logic                  s_ar_sec_err_i,
  output logic                  s_arready,
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [CNT_WIDTH-1:0]  dec_err_cnt_o,
  output logic [CNT_WIDTH-1:0]  sec_err_cnt_o
);

  // The write burst length is not needed: wlast alone ends the data phase.
  logic unused_awlen;
  assign unused_awlen = ^s_awlen;

  wr_state_e           wr_state_q, wr_state_d;
  logic [ID_WIDTH-1:0] bid_q;
  logic [1:0]          bresp_q;

  rd_state_e           rd_state_q, rd_state_d;
  logic [ID_WIDTH-1:0] rid_q;
  logic [1:0]          rresp_q;
  logic [7:0]          rlen_q;
  logic [7:0]          beat_q, beat_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, r_last_beat;

  // Readys and valids come straight from state, never from the opposing valid.
  assign s_awready = (wr_state_q == W_IDLE);
  assign s_wready  = (wr_state_q == W_DATA);
  assign s_bvalid  = (wr_state_q == W_RESP);
  assign s_bid     = bid_q;
  assign s_bresp   = bresp_q;

  assign s_arready = (rd_state_q == R_IDLE);
  assign s_rvalid  = (rd_state_q == R_DATA);
  assign s_rid     = rid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = '0;

  assign r_last_beat = (beat_q == rlen_q);
  assign s_rlast     = s_rvalid & r_last_beat;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid  & s_wready;
  assign b_hs  = s_bvalid  & s_bready;
  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid  & s_rready;

  // Write sequencing: address, data until wlast, then a single response.
  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      W_IDLE:  if (aw_hs)           wr_state_d = W_DATA;
      W_DATA:  if (w_hs && s_wlast) wr_state_d = W_RESP;
      W_RESP:  if (b_hs)            wr_state_d = W_IDLE;
      default:                      wr_state_d = W_IDLE;
    endcase
  end

  // Write state and the id/resp captured with the address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= W_IDLE;
      bid_q      <= '0;
      bresp_q    <= AXI_RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      if (aw_hs) begin
        bid_q   <= s_awid;
        bresp_q <= err_resp(s_aw_sec_err_i);
      end
    end
  end

  // Read sequencing: arlen+1 beats, leaving after the rlast handshake.
  always_comb begin
    rd_state_d = rd_state_q;
    beat_d     = beat_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_state_d = R_DATA;
          beat_d     = '0;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          if (r_last_beat) rd_state_d = R_IDLE;
          else             beat_d     = beat_q + 8'd1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read state, beat counter and the id/len/resp captured with the address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_q <= R_IDLE;
      beat_q     <= '0;
      rid_q      <= '0;
      rresp_q    <= AXI_RESP_OKAY;
      rlen_q     <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      beat_q     <= beat_d;
      if (ar_hs) begin
        rid_q   <= s_arid;
        rresp_q <= err_resp(s_ar_sec_err_i);
        rlen_q  <= s_arlen;
      end
    end
  end

  logic [1:0] dec_inc, sec_inc;

  // Each accepted address adds one to the counter of its error kind.
  always_comb begin
    dec_inc = {1'b0, aw_hs & ~s_aw_sec_err_i} + {1'b0, ar_hs & ~s_ar_sec_err_i};
    sec_inc = {1'b0, aw_hs &  s_aw_sec_err_i} + {1'b0, ar_hs &  s_ar_sec_err_i};
  end

  bus_matrix_sat_cnt #(.WIDTH(CNT_WIDTH)) u_dec_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (dec_inc),
    .cnt_o (dec_err_cnt_o)
  );

  bus_matrix_sat_cnt #(.WIDTH(CNT_WIDTH)) u_sec_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (sec_inc),
    .cnt_o (sec_err_cnt_o)
  );

endmodule

// File: tb/tb_bus_matrix_error_slave.sv
// Bench for the bus-matrix error slave: a randomised AXI master drives two
// instances (16-bit and 2-bit counters) and a transaction-level model predicts
// every output each cycle.
module tb_bus_matrix_error_slave;

  localparam int IDW = 4;
  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int CWS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [IDW-1:0] awid, arid;
  logic [7:0]     awlen, arlen;
  logic           awvalid, awsec, wlast, wvalid, bready, arvalid, arsec, rready;

  logic           m_awready, m_wready, m_bvalid, m_arready, m_rlast, m_rvalid;
  logic [IDW-1:0] m_bid, m_rid;
  logic [1:0]     m_bresp, m_rresp;
  logic [DW-1:0]  m_rdata;
  logic [CW-1:0]  m_dec, m_sec;

  logic           n_awready, n_wready, n_bvalid, n_arready, n_rlast, n_rvalid;
  logic [IDW-1:0] n_bid, n_rid;
  logic [1:0]     n_bresp, n_rresp;
  logic [DW-1:0]  n_rdata;
  logic [CWS-1:0] n_dec, n_sec;

  bus_matrix_error_slave #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .s_awid(awid), .s_awlen(awlen), .s_awvalid(awvalid), .s_aw_sec_err_i(awsec), .s_awready(m_awready),
    .s_wlast(wlast), .s_wvalid(wvalid), .s_wready(m_wready),
    .s_bid(m_bid), .s_bresp(m_bresp), .s_bvalid(m_bvalid), .s_bready(bready),
    .s_arid(arid), .s_arlen(arlen), .s_arvalid(arvalid), .s_ar_sec_err_i(arsec), .s_arready(m_arready),
    .s_rid(m_rid), .s_rdata(m_rdata), .s_rresp(m_rresp), .s_rlast(m_rlast), .s_rvalid(m_rvalid), .s_rready(rready),
    .dec_err_cnt_o(m_dec), .sec_err_cnt_o(m_sec)
  );

  bus_matrix_error_slave #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .CNT_WIDTH(CWS)) u_small (
    .clk_i(clk), .rst_i(rst),
    .s_awid(awid), .s_awlen(awlen), .s_awvalid(awvalid), .s_aw_sec_err_i(awsec), .s_awready(n_awready),
    .s_wlast(wlast), .s_wvalid(wvalid), .s_wready(n_wready),
    .s_bid(n_bid), .s_bresp(n_bresp), .s_bvalid(n_bvalid), .s_bready(bready),
    .s_arid(arid), .s_arlen(arlen), .s_arvalid(arvalid), .s_ar_sec_err_i(arsec), .s_arready(n_arready),
    .s_rid(n_rid), .s_rdata(n_rdata), .s_rresp(n_rresp), .s_rlast(n_rlast), .s_rvalid(n_rvalid), .s_rready(rready),
    .dec_err_cnt_o(n_dec), .sec_err_cnt_o(n_sec)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding write, a queue of read beats.
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [1:0]     resp;
    logic           last;
  } beat_t;

  beat_t          rq[$];
  bit             wb_busy, wb_last;
  logic [IDW-1:0] wb_id;
  logic [1:0]     wb_resp;
  int             dec_n, sec_n;
  bit             chk_en, was_reset;

  // Master-side state and knobs.
  int  wq[$];
  int  w_sent, r_taken;
  int  p_aw, p_w, p_b, p_ar, p_r;
  int  aw_budget, ar_budget;
  bit  dir, r_toggle;
  logic [IDW-1:0] d_awid, d_arid;
  logic           d_awsec, d_arsec;
  logic [7:0]     d_awlen, d_arlen;
  bit  aw_hs, w_hs, b_hs, ar_hs, r_hs;

  function automatic logic [1:0] resp_of(input logic sec);
    return sec ? 2'b10 : 2'b11;
  endfunction

  function automatic int sat(input int n, input int w);
    int lim = (1 << w) - 1;
    return (n > lim) ? lim : n;
  endfunction

  task automatic check_dut(input string p, input int cw,
                           input logic awr, input logic wr, input logic bv,
                           input logic [IDW-1:0] bid, input logic [1:0] bresp,
                           input logic arr, input logic rv, input logic rl,
                           input logic [IDW-1:0] rid, input logic [1:0] rresp,
                           input logic [DW-1:0] rdata,
                           input logic [CW-1:0] dec, input logic [CW-1:0] sec);
    beat_t f;
    bit    have = (rq.size() != 0);
    f = have ? rq[0] : '0;
    chk({p, "awready"}, 64'(awr), 64'(!wb_busy));
    chk({p, "wready"},  64'(wr),  64'(wb_busy && !wb_last));
    chk({p, "bvalid"},  64'(bv),  64'(wb_busy && wb_last));
    if ((wb_busy && wb_last) || was_reset) begin
      chk({p, "bid"},   64'(bid),   64'(wb_id));
      chk({p, "bresp"}, 64'(bresp), 64'(wb_resp));
    end
    chk({p, "arready"}, 64'(arr), 64'(!have));
    chk({p, "rvalid"},  64'(rv),  64'(have));
    chk({p, "rlast"},   64'(rl),  64'(f.last));
    if (have || was_reset) begin
      chk({p, "rid"},   64'(rid),   64'(f.id));
      chk({p, "rresp"}, 64'(rresp), 64'(f.resp));
    end
    chk({p, "rdata"},   64'(rdata), 64'(0));
    chk({p, "dec_cnt"}, 64'(dec),   64'(sat(dec_n, cw)));
    chk({p, "sec_cnt"}, 64'(sec),   64'(sat(sec_n, cw)));
  endtask

  // One clock: check outputs, drive inputs, advance the model by the
  // handshakes that the coming rising edge will complete.
  task automatic cycle(input bit do_rst);
    @(negedge clk);
    if (chk_en) begin
      check_dut("",   CW,  m_awready, m_wready, m_bvalid, m_bid, m_bresp,
                m_arready, m_rvalid, m_rlast, m_rid, m_rresp, m_rdata, m_dec, m_sec);
      check_dut("n_", CWS, n_awready, n_wready, n_bvalid, n_bid, n_bresp,
                n_arready, n_rvalid, n_rlast, n_rid, n_rresp, n_rdata, CW'(n_dec), CW'(n_sec));
    end
    was_reset = 0;
    if (do_rst) begin
      rst = 1'b1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      wq.delete(); w_sent = 0;
      rq.delete(); wb_busy = 0; wb_last = 0; wb_id = '0; wb_resp = 2'b00;
      dec_n = 0; sec_n = 0;
      was_reset = 1; chk_en = 1;
      return;
    end
    rst = 1'b0;
    if (aw_hs) awvalid = 1'b0;
    if (w_hs)  wvalid  = 1'b0;
    if (ar_hs) arvalid = 1'b0;

    if (!awvalid && aw_budget > 0 && $urandom_range(99) < p_aw) begin
      awvalid = 1'b1;
      if (dir) begin awid = d_awid; awsec = d_awsec; awlen = d_awlen; end
      else begin awid = IDW'($urandom); awsec = 1'($urandom); awlen = 8'($urandom_range(5)); end
      aw_budget--;
      wq.push_back(int'(awlen) + 1);
    end
    if (!wvalid && wq.size() > 0 && $urandom_range(99) < p_w) begin
      wvalid = 1'b1;
      wlast  = (w_sent + 1 == wq[0]);
    end
    if (!arvalid && ar_budget > 0 && $urandom_range(99) < p_ar) begin
      arvalid = 1'b1;
      if (dir) begin arid = d_arid; arsec = d_arsec; arlen = d_arlen; end
      else begin arid = IDW'($urandom); arsec = 1'($urandom); arlen = 8'($urandom_range(7)); end
      ar_budget--;
    end
    bready = ($urandom_range(99) < p_b);
    rready = r_toggle ? !rready : ($urandom_range(99) < p_r);

    aw_hs = awvalid && !wb_busy;
    w_hs  = wvalid && wb_busy && !wb_last;
    b_hs  = bready && wb_busy && wb_last;
    ar_hs = arvalid && (rq.size() == 0);
    r_hs  = rready && (rq.size() != 0);

    if (b_hs) wb_busy = 0;
    if (w_hs) begin
      w_sent++;
      if (wlast) begin wb_last = 1; w_sent = 0; void'(wq.pop_front()); end
    end
    if (aw_hs) begin
      wb_busy = 1; wb_last = 0; wb_id = awid; wb_resp = resp_of(awsec);
      if (awsec) sec_n++; else dec_n++;
    end
    if (r_hs) begin void'(rq.pop_front()); r_taken++; end
    if (ar_hs) begin
      for (int i = 0; i <= int'(arlen); i++) begin
        beat_t b;
        b.id = arid; b.resp = resp_of(arsec); b.last = (i == int'(arlen));
        rq.push_back(b);
      end
      if (arsec) sec_n++; else dec_n++;
    end
  endtask

  task automatic run_idle(input string tag, input int max);
    int n = 0;
    do begin
      cycle(0);
      n++;
    end while (n < max && !(aw_budget == 0 && ar_budget == 0 && !wb_busy &&
                            rq.size() == 0 && wq.size() == 0 && !(awvalid && !aw_hs) &&
                            !(arvalid && !ar_hs)));
    chk({tag, "_complete"}, 64'(n < max), 64'(1));
  endtask

  initial begin
    rst = 1'b1; awid = '0; arid = '0; awlen = '0; arlen = '0;
    awvalid = 0; awsec = 0; wlast = 0; wvalid = 0; bready = 0;
    arvalid = 0; arsec = 0; rready = 0;
    p_aw = 100; p_w = 100; p_b = 100; p_ar = 100; p_r = 100;
    aw_budget = 0; ar_budget = 0; dir = 1; r_toggle = 0;
    w_sent = 0; r_taken = 0; chk_en = 0;
    cycle(1); cycle(1);
    cycle(0); cycle(0);

    // Decode-error write, four data beats.
    d_awid = 4'd3; d_awsec = 1'b0; d_awlen = 8'd3; aw_budget = 1;
    run_idle("wr4", 40);
    chk("wr4_dec_cnt", 64'(m_dec), 64'(1));

    // Security-violation read, four beats.
    d_arid = 4'd5; d_arsec = 1'b1; d_arlen = 8'd3; ar_budget = 1;
    run_idle("rd4", 40);
    chk("rd4_sec_cnt", 64'(m_sec), 64'(1));

    // Single-beat read with rready toggling.
    d_arid = 4'd9; d_arsec = 1'b0; d_arlen = 8'd0; ar_budget = 1; r_toggle = 1;
    run_idle("rd1", 40);
    r_toggle = 0;

    // Simultaneous decode-error AW and AR.
    d_awid = 4'd1; d_awlen = 8'd1; d_arid = 4'd2; d_arlen = 8'd2;
    aw_budget = 1; ar_budget = 1;
    run_idle("both", 40);
    chk("both_dec_cnt", 64'(m_dec), 64'(4));

    // Fifth decode error: 2-bit counter stays saturated.
    aw_budget = 1; d_awlen = 8'd0;
    run_idle("sat", 40);
    chk("sat_dec_big",   64'(m_dec), 64'(5));
    chk("sat_dec_small", 64'(n_dec), 64'(3));

    // Maximum-length read: 256 beats, rlast only on the last.
    d_arlen = 8'd255; d_arsec = 1'b1; ar_budget = 1;
    run_idle("rd256", 300);

    // Reset in the middle of an eight-beat read.
    d_arlen = 8'd7; d_arsec = 1'b0; ar_budget = 1; r_taken = 0;
    begin
      int n = 0;
      while (r_taken < 2 && n < 30) begin cycle(0); n++; end
      chk("mid_rst_reached", 64'(r_taken), 64'(2));
    end
    cycle(1);
    cycle(0);
    chk("post_rst_dec", 64'(m_dec), 64'(0));
    d_arid = 4'd6; d_arlen = 8'd2; ar_budget = 1;
    run_idle("after_rst", 40);

    // Randomised traffic with occasional reset.
    dir = 0; aw_budget = 1000000; ar_budget = 1000000;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        p_aw = $urandom_range(20, 100); p_w = $urandom_range(20, 100);
        p_b  = $urandom_range(20, 100); p_ar = $urandom_range(20, 100);
        p_r  = $urandom_range(20, 100);
      end
      cycle($urandom_range(499) == 0);
    end
    aw_budget = 0; ar_budget = 0; p_w = 100; p_b = 100; p_r = 100;
    run_idle("drain", 200);
    cycle(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_matrix_error_slave.md
# bus_matrix_error_slave

AXI4 responder that terminates every transaction the bus matrix cannot route to a real slave: unmapped addresses (decode error) and secure-region accesses by non-secure masters (security violation). It sits on the slave side of the matrix in the default-slave position, accepts the full address/data handshake so the initiating master never stalls, and returns DECERR or SLVERR with the correct ID and burst length. It also keeps saturating error counters for status registers.

## Interface
- ID_WIDTH, 4, AXI ID width (matrix-extended ID).
- DATA_WIDTH, 32, AXI data width; read data returned as all zeros.
- CNT_WIDTH, 16, width of each saturating error counter.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- s_awid/awlen/awvalid  in  ID_WIDTH/8/1  write address channel (address not needed).
- s_aw_sec_err_i  in  1  qualifies AW: 1 = security violation, 0 = decode error.
- s_awready  out  1.
- s_wlast/wvalid  in  1/1; s_wready  out  1 (data and strobes ignored).
- s_bid/bresp/bvalid  out  ID_WIDTH/2/1; s_bready  in  1.
- s_arid/arlen/arvalid  in  ID_WIDTH/8/1; s_ar_sec_err_i  in  1; s_arready  out  1.
- s_rid/rdata/rresp/rlast/rvalid  out  ID_WIDTH/DATA_WIDTH/2/1/1; s_rready  in  1.
- dec_err_cnt_o, sec_err_cnt_o  out  CNT_WIDTH  saturating counts of accepted errored AW+AR.

## Operation
- Write FSM (independent of read): W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1; on awvalid capture awid, resp = sec_err ? 2'b10 (SLVERR) : 2'b11 (DECERR); go W_DATA.
  - W_DATA: wready=1; every wvalid beat consumed; beat with wlast -> W_RESP. awlen ignored; wlast is authoritative.
  - W_RESP: bvalid=1, bid/bresp from capture; on bready -> W_IDLE.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1; on arvalid capture arid, arlen, resp code; clear beat counter; go R_DATA.
  - R_DATA: rvalid=1, rdata=0, rresp=captured, rid=captured, rlast=(beat_cnt==len). beat_cnt increments on rvalid&rready; rlast handshake -> R_IDLE.
- Beat counter 8 bits; len 0 gives exactly one beat; len 255 gives 256 beats, no wrap before rlast.
- Counters: on each AW or AR handshake increment the selected counter by 1; simultaneous AW and AR of same type add 2; different types add 1 each. Saturate at all-ones, never wrap.
- Only one outstanding transaction per direction; further AW/AR back-pressured by ready=0.

## Timing
- Reset: both FSMs idle; awready=arready=1 on first cycle after reset deassertion; wready, bvalid, rvalid, rlast=0; bid, bresp, rid, rresp, rdata=0; counters=0.
- Reset mid-transaction: abandon in-flight burst immediately, no response issued.
- All outputs registered/state-decoded; no combinational path from any valid to any ready.
- AW handshake cycle N -> wready from N+1; W beat with wlast at cycle M -> bvalid at M+1.
- AR handshake cycle N -> first rvalid at N+1; one beat per cycle when rready held high.
- W beats before AW accepted: wready=0, held off.
- bvalid/rvalid, once high, held with stable payload until handshake.

## Structure
- bus_matrix_pkg gains: AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR localparams (2-bit), and typedefs wr_state_e {W_IDLE, W_DATA, W_RESP} and rd_state_e {R_IDLE, R_DATA}.
- One sub-module: bus_matrix_sat_cnt (parameterized width, inc-by-0/1/2, saturating), instantiated twice.

## Test plan
- AW id=3, sec_err=0, 4 W beats (wlast on 4th), bready=1 -> wready 4 cycles, bvalid one cycle after last beat, bid=3, bresp=2'b11; dec_err_cnt=1.
- AR id=5, arlen=3, sec_err=1, rready=1 -> 4 consecutive R beats, rdata=0, rresp=2'b10, rid=5, rlast only on 4th; sec_err_cnt=1.
- AR arlen=0 with rready toggled 0/1 -> single beat, rlast=1, rvalid/payload stable while rready=0.
- Simultaneous AW and AR both sec_err=0 -> both accepted same cycle, dec_err_cnt +2; both FSMs complete independently.
- CNT_WIDTH=2, five decode errors -> dec_err_cnt sticks at 3.
- Assert rst_i during R_DATA beat 2 of 8 -> next cycle rvalid=0, arready=1, counters=0; new AR served normally.
